// File: rtl/truth_table_scanner.sv
// Truth-table scanner: steps a 4-input gate through every input vector,
// captures Y for each one, and compares the captured table against EXPECTED.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for i_start; o_vec = 0, o_busy = 0
// ST_SETTLE  | o_vec = idx held steady; cnt counts SETTLE cycles down to 0
// ST_SAMPLE  | capture i_y into o_table[idx] and update the error stats
// ST_DONE    | one-cycle o_done pulse; o_match is latched from o_err_cnt
module truth_table_scanner #(
  parameter int                 N_IN     = 4,
  parameter int                 SETTLE   = 1,
  parameter logic [2**N_IN-1:0] EXPECTED = 16'h0055
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  output logic [N_IN-1:0]      o_vec,
  input  logic                 i_y,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2**N_IN-1:0]   o_table,
  output logic                 o_match,
  output logic [N_IN:0]        o_err_cnt,
  output logic [N_IN-1:0]      o_first_err_idx
);

  // The settle counter only ever holds SETTLE-1 down to 0.
  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(2**N_IN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [CW-1:0]   cnt;

  // Sweep sequencer; every output is registered so o_vec never glitches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= ST_IDLE;
      idx             <= '0;
      cnt             <= '0;
      o_vec           <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_table         <= '0;
      o_match         <= 1'b0;
      o_err_cnt       <= '0;
      o_first_err_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            idx             <= '0;
            o_vec           <= '0;
            o_table         <= '0;
            o_err_cnt       <= '0;
            o_first_err_idx <= '0;
            o_match         <= 1'b0;
            cnt             <= CNT_LOAD;
            o_busy          <= 1'b1;
            state           <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (cnt == '0) begin
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_SAMPLE: begin
          o_table[idx] <= i_y;
          if (i_y != EXPECTED[idx]) begin
            o_err_cnt <= o_err_cnt + 1'b1;
            // Only the first mismatch of the sweep records its index.
            if (o_err_cnt == '0) begin
              o_first_err_idx <= idx;
            end
          end
          if (idx == IDX_LAST) begin
            o_vec  <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= ST_DONE;
          end else begin
            idx   <= idx + 1'b1;
            o_vec <= idx + 1'b1;
            cnt   <= CNT_LOAD;
            state <= ST_SETTLE;
          end
        end

        ST_DONE: begin
          // The last SAMPLE has already committed its error count.
          o_done  <= 1'b0;
          o_match <= (o_err_cnt == '0);
          state   <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: behavioural gate models on the vector bus,
// a table of sweeps with hand-computed results, plus hand-written multi-cycle
// sequences (ignored starts, held start, mid-sweep reset, longer settle).
module tb_truth_table_scanner;

  logic        clk;
  logic        rst_n;
  logic        start0, start1;
  logic [3:0]  vec0, vec1;
  logic        y0, y1;
  logic        busy0, busy1;
  logic        done0, done1;
  logic [15:0] table0, table1;
  logic        match0, match1;
  logic [4:0]  err0, err1;
  logic [3:0]  first0, first1;
  int          mode0, mode1;
  int          total;
  int          bad;

  // Gate models; A = vec[3], D = vec[0].
  function automatic logic gate(input int mode, input logic [3:0] v);
    logic a, d;
    a = v[3];
    d = v[0];
    case (mode)
      0:       gate = ~a & ~d;
      1:       gate = 1'b0;
      2:       gate = ~d;
      3:       gate = 1'b1;
      4:       gate = a;
      default: gate = a | d;
    endcase
  endfunction

  assign y0 = gate(mode0, vec0);
  assign y1 = gate(mode1, vec1);

  truth_table_scanner u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .o_vec(vec0), .i_y(y0),
    .o_busy(busy0), .o_done(done0), .o_table(table0), .o_match(match0),
    .o_err_cnt(err0), .o_first_err_idx(first0)
  );

  truth_table_scanner #(.SETTLE(3)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .o_vec(vec1), .i_y(y1),
    .o_busy(busy1), .o_done(done1), .o_table(table1), .o_match(match1),
    .o_err_cnt(err1), .o_first_err_idx(first1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One start pulse, then follow the sweep cycle by cycle. Cycle 1 is the
  // cycle after the edge that samples i_start.
  task automatic sweep(input int which, input bit extra, input int s);
    int per, last, ndone, done_cyc;
    per      = s + 1;
    last     = 16 * per;
    ndone    = 0;
    done_cyc = -1;
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= last + 8; k++) begin
      if (k <= last) begin
        chk("vec_step", (which == 0) ? vec0 : vec1, (k - 1) / per);
        chk("busy",     (which == 0) ? busy0 : busy1, 1);
      end
      if ((which == 0) ? done0 : done1) begin
        ndone++;
        done_cyc = k;
      end
      if (extra && (k == 5 || k == 20)) begin
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
      end else begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
      @(negedge clk);
    end
    chk("done_count", ndone, 1);
    chk("done_cycle", done_cyc, last + 1);
    chk("idle_busy", (which == 0) ? busy0 : busy1, 0);
    chk("idle_vec",  (which == 0) ? vec0 : vec1, 0);
  endtask

  typedef struct {
    int          mode;
    logic [15:0] tbl;
    logic [4:0]  err;
    logic [3:0]  first;
    logic        match;
  } vec_t;

  vec_t vt[6];

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    mode0  = 0;
    mode1  = 0;

    vt[0] = '{mode: 0, tbl: 16'h0055, err: 5'd0,  first: 4'd0, match: 1'b1};
    vt[1] = '{mode: 1, tbl: 16'h0000, err: 5'd4,  first: 4'd0, match: 1'b0};
    vt[2] = '{mode: 2, tbl: 16'h5555, err: 5'd4,  first: 4'd8, match: 1'b0};
    vt[3] = '{mode: 3, tbl: 16'hFFFF, err: 5'd12, first: 4'd1, match: 1'b0};
    vt[4] = '{mode: 4, tbl: 16'hFF00, err: 5'd12, first: 4'd0, match: 1'b0};
    vt[5] = '{mode: 5, tbl: 16'hFFAA, err: 5'd16, first: 4'd0, match: 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_vec",   vec0, 0);
    chk("rst_busy",  busy0, 0);
    chk("rst_done",  done0, 0);
    chk("rst_table", table0, 0);
    chk("rst_match", match0, 0);
    chk("rst_err",   err0, 0);
    chk("rst_first", first0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      mode0 = vt[i].mode;
      sweep(0, 1'b0, 1);
      chk("tv_table", table0, vt[i].tbl);
      chk("tv_err",   err0,   vt[i].err);
      chk("tv_first", first0, vt[i].first);
      chk("tv_match", match0, vt[i].match);
    end

    // Results persist in IDLE until the next accepted start.
    repeat (5) @(negedge clk);
    chk("hold_table", table0, 16'hFFAA);
    chk("hold_err",   err0, 16);

    // Stray start pulses during the sweep are ignored.
    mode0 = 0;
    sweep(0, 1'b1, 1);
    chk("extra_table", table0, 16'h0055);
    chk("extra_match", match0, 1);

    // Longer settle time.
    mode1 = 0;
    sweep(1, 1'b0, 3);
    chk("s3_table", table1, 16'h0055);
    chk("s3_err",   err1, 0);
    chk("s3_match", match1, 1);

    // Start held high: a new sweep begins on the IDLE cycle after DONE.
    mode0 = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    for (int k = 1; k < 35; k++) begin
      if (k == 33) chk("held_done33", done0, 1);
      @(negedge clk);
    end
    chk("held_restart_busy",  busy0, 1);
    chk("held_restart_table", table0, 0);
    chk("held_restart_err",   err0, 0);
    start0 = 1'b0;
    for (int i = 0; i < 40 && !done0; i++) @(negedge clk);
    chk("held_second_done", done0, 1);
    @(negedge clk);
    chk("held_second_table", table0, 16'h0000);
    chk("held_second_err",   err0, 4);

    // Reset while idx = 7 clears everything at once and never pulses o_done.
    mode0 = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 40 && vec0 != 4'd7; i++) @(negedge clk);
    chk("mid_reach7", vec0, 7);
    rst_n = 1'b0;
    #1;
    chk("mid_vec",   vec0, 0);
    chk("mid_busy",  busy0, 0);
    chk("mid_done",  done0, 0);
    chk("mid_table", table0, 0);
    chk("mid_err",   err0, 0);
    chk("mid_first", first0, 0);
    chk("mid_match", match0, 0);
    repeat (2) @(negedge clk);
    chk("mid_nodone", done0, 0);
    chk("mid_nobusy", busy0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    sweep(0, 1'b0, 1);
    chk("post_rst_table", table0, 16'h0055);
    chk("post_rst_match", match0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
